// File: rtl/uart_tx.sv
// Write-only 8N1 UART transmitter with a byte FIFO and a same-cycle accept/reject error flag.
// Optional: define UART_SIM_PRINT_EN to echo every accepted byte to the simulator console.
module uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_cen,
  input  logic             uart_wr,
  input  logic [7:0]       uart_wdata,
  output logic             uart_error,
  output logic             uart_txd,
  output logic             tx_busy,
  output logic [FIFO_AW:0] fifo_level
);

  localparam int unsigned BAUD_W = $clog2(CLK_DIV);
  localparam int unsigned LVL_W  = FIFO_AW + 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL    = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e              state_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [2:0]          bit_q;
  logic [7:0]          shift_q;
  logic                txd_q;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wptr_q;
  logic [FIFO_AW-1:0]  rptr_q;
  logic [LVL_W-1:0]    level_q;

  logic full_c, empty_c, push_c, pop_c, baud_done_c;

  assign full_c      = (level_q == LVL_FULL);
  assign empty_c     = (level_q == '0);
  assign baud_done_c = (baud_q == '0);
  assign push_c      = uart_cen & uart_wr & ~full_c;
  // Pop when idle, or at the last cycle of a stop bit so frames run back-to-back.
  assign pop_c       = ~empty_c & ((state_q == IDLE) | ((state_q == STOP) & baud_done_c));

  assign uart_error  = uart_cen & (~uart_wr | full_c);
  assign uart_txd    = txd_q;
  assign tx_busy     = (state_q != IDLE) | ~empty_c;
  assign fifo_level  = level_q;

  // Storage array carries no reset; validity is tracked by level_q.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wptr_q] <= uart_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_c) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop_c)  rptr_q <= rptr_q + FIFO_AW'(1);
      case ({push_c, pop_c})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (pop_c) begin
            shift_q <= mem_q[rptr_q];
            baud_q  <= BAUD_RELOAD;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_done_c) begin
            baud_q  <= BAUD_RELOAD;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_done_c) begin
            baud_q <= BAUD_RELOAD;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              txd_q   <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_done_c) begin
            if (pop_c) begin
              shift_q <= mem_q[rptr_q];
              baud_q  <= BAUD_RELOAD;
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_SIM_PRINT_EN
  always_ff @(posedge clk) begin
    if (push_c) $write("%c", uart_wdata);
  end
`endif

endmodule
